// File: rtl/pmod_da4_pkg.sv
// pmod_da4_pkg: shared constants, frame helpers and FSM encoding for the PmodDA4 SPI transmitter
package pmod_da4_pkg;

    localparam int          FRAME_W          = 32;
    localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0]  CMD_SETUP_REF    = 4'b1000;
    localparam logic [3:0]  ADDR_ALL         = 4'hF;
    localparam logic [31:0] SETUP_WORD       = {4'h0, CMD_SETUP_REF, 24'h000001};

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // AD5628 write-and-update frame: {prefix, command, address, 12-bit code, don't-care byte}
    function automatic logic [FRAME_W-1:0] data_frame(input logic [3:0] ch, input logic [11:0] code);
        return {4'h0, CMD_WRITE_UPDATE, ch, code, 8'h00};
    endfunction

endpackage

// File: rtl/pmod_da4_shifter.sv
// pmod_da4_shifter: MSB-first 32-bit SPI shift engine with SCLK divider and bit counter
module pmod_da4_shifter
    import pmod_da4_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] word,
    output logic               sclk,
    output logic               sync_n,
    output logic               mosi,
    output logic               done
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic               active_q, active_d;
    logic               sclk_q, sclk_d;
    logic               sync_n_q, sync_n_d;
    logic               mosi_q, mosi_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [4:0]         bit_q, bit_d;
    logic [DW-1:0]      div_q, div_d;
    logic               half_end;

    // Next state: each bit is a high half then a low half; MOSI only moves when SCLK rises
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        mosi_d   = mosi_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        div_d    = div_q;
        half_end = div_q == DIV_LAST;
        done     = active_q && half_end && !sclk_q && bit_q == 5'd31;
        if (load) begin
            active_d = 1'b1;
            sclk_d   = 1'b1;
            sync_n_d = 1'b0;
            mosi_d   = word[FRAME_W-1];
            sh_d     = {word[FRAME_W-2:0], 1'b0};
            bit_d    = '0;
            div_d    = '0;
        end else if (active_q) begin
            div_d = half_end ? '0 : div_q + 1'b1;
            if (half_end && sclk_q) begin
                sclk_d = 1'b0;
            end else if (done) begin
                active_d = 1'b0;
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                mosi_d   = 1'b0;
            end else if (half_end) begin
                sclk_d = 1'b1;
                mosi_d = sh_q[FRAME_W-1];
                sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                bit_d  = bit_q + 5'd1;
            end
        end
    end

    // Shift engine registers; reset drops any frame in flight and idles the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            mosi_q   <= 1'b0;
            sh_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            mosi_q   <= mosi_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
        end
    end

    assign sclk   = sclk_q;
    assign sync_n = sync_n_q;
    assign mosi   = mosi_q;

endmodule

// File: rtl/pmod_da4_spi_tx.sv
// pmod_da4_spi_tx: valid/ready sample sink that frames 12-bit codes for the AD5628 DAC over SPI
module pmod_da4_spi_tx
    import pmod_da4_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] CHANNEL    = ADDR_ALL,
    parameter bit         INT_REF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        spi_sclk,
    output logic        spi_sync_n,
    output logic        spi_mosi
);

    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               load;
    logic [FRAME_W-1:0] word;
    logic               done;

    // Sequencing: optional reference setup, then accept, shift, and hold SYNC high for the gap
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        gap_d   = gap_q;
        load    = 1'b0;
        word    = SETUP_WORD;
        case (state_q)
            ST_INIT: begin
                if (INT_REF) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (din_valid && ready_q) begin
                    load    = 1'b1;
                    word    = data_frame(CHANNEL, din);
                    ready_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (done) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control registers; reset returns to INIT so the setup frame is resent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            gap_q   <= gap_d;
        end
    end

    pmod_da4_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .word  (word),
        .sclk  (spi_sclk),
        .sync_n(spi_sync_n),
        .mosi  (spi_mosi),
        .done  (done)
    );

    assign din_ready = ready_q;

endmodule
